multicycle_sequencer: RTL and testbench

- Control FSM that turns the single-cycle datapath into a multicycle one sharing a single unified instruction/data memory port.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Raises the architectural write enables (IR, PC, register file, data memory) only in the correct step.
- Sits beside the existing combinational control decoder: that decoder still produces the mux selects and ALU/branch/memory codes; this block gates and times them.

---
 rtl/multicycle_sequencer.sv | 175 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: step controller for a multicycle datapath that shares
// one unified instruction/data memory port. Each instruction is stepped
// through FETCH, DECODE, EXEC, optional MEM, and WB. The architectural write
// enables are raised only in the step where they are valid. The external
// combinational decoder still drives the mux selects and the ALU, branch and
// memory codes.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   OpCode[6:0]             opcode field from the IR, valid from DECODE onward
//   mem_ready               memory acknowledge, looked at only while mem_req=1
//   mem_req/mem_we/mem_sel  memory request, write strobe, address select (0=PC, 1=ALU)
//   IRWr                    IR load pulse, qualified by mem_ready in FETCH
//   PCWr                    PC update / retire strobe in WB
//   RUWrEn                  register-file write gate in WB
//   state[2:0]              current step, for debug
//   illegal                 sticky flag, set on entry to TRAP
//   halted                  high in HALT or TRAP
//   cycle_cnt, instr_cnt    performance counters (CNT_W bits)
//
// Build option: define SEQ_PERF_CNT_EN to build the performance counters.
// When it is undefined, cycle_cnt and instr_cnt are tied to zero.
module multicycle_sequencer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       OpCode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel,
  output logic             IRWr,
  output logic             PCWr,
  output logic             RUWrEn,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int unsigned OP_W = 7;

  localparam logic [OP_W-1:0] OP_ALU    = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ALUI   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   op_legal;
  logic   op_mem;
  logic   op_store;
  logic   op_no_rd;
  logic   illegal_q;

  // Opcode classification used by the step sequencing
  always_comb begin
    op_legal = 1'b0;
    case (OpCode)
      OP_ALU, OP_ALUI, OP_LOAD, OP_JALR, OP_BRANCH,
      OP_STORE, OP_JAL, OP_LUI, OP_AUIPC: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  end

  assign op_store = (OpCode == OP_STORE);
  assign op_mem   = (OpCode == OP_LOAD) || op_store;
  assign op_no_rd = (OpCode == OP_BRANCH) || op_store;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  // Next-state logic; HALT and TRAP are left only through reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (op_legal)                 state_d = S_EXEC;
        else if (OpCode == OP_SYSTEM) state_d = S_HALT;
        else                          state_d = S_TRAP;
      end
      S_EXEC:   state_d = op_mem ? S_MEM : S_WB;
      S_MEM:    if (mem_ready) state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = state_q;
    endcase
  end

  // Moore outputs decoded from the state; IRWr is additionally qualified by mem_ready
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    mem_sel = 1'b0;
    IRWr    = 1'b0;
    PCWr    = 1'b0;
    RUWrEn  = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        IRWr    = mem_ready;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = op_store;
      end
      S_WB: begin
        PCWr   = 1'b1;
        RUWrEn = !op_no_rd;
      end
      S_HALT, S_TRAP: halted = 1'b1;
      default: ;
    endcase
  end

  // Sticky illegal-opcode flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     illegal_q <= 1'b0;
    else if (state_q == S_DECODE && state_d == S_TRAP) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
  assign state   = state_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instr_q;
  logic             active;

  assign active = !(state_q inside {S_INIT, S_HALT, S_TRAP});

  // Performance counters; they wrap silently and freeze in HALT/TRAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (active)         cycle_q <= cycle_q + CNT_W'(1);
      if (state_q == S_WB) instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer. Each instruction pushes its
// expected per-cycle output trace and the mem_ready pattern into a scoreboard
// queue. The queue is then drained one cycle at a time, and every entry is
// compared with the DUT outputs.
module tb_multicycle_sequencer;

  localparam int unsigned CW = 4;
`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] ALU    = 7'b0110011;
  localparam logic [6:0] ALUI   = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    OpCode = 7'd0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, mem_sel, IRWr, PCWr, RUWrEn, illegal, halted;
  logic [2:0]    state;
  logic [CW-1:0] cycle_cnt, instr_cnt;

  multicycle_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .IRWr(IRWr),
    .PCWr(PCWr), .RUWrEn(RUWrEn), .state(state), .illegal(illegal),
    .halted(halted), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // {state, mem_req, mem_we, mem_sel, IRWr, PCWr, RUWrEn, illegal, halted}
  logic [10:0] obs;
  assign obs = {state, mem_req, mem_we, mem_sel, IRWr, PCWr, RUWrEn, illegal, halted};

  typedef struct packed {
    logic [6:0]  opc;
    logic        rdy;
    logic [10:0] exp;
  } rec_t;

  rec_t          sbq[$];
  int            total = 0;
  int            bad = 0;
  logic [CW-1:0] acc_cyc = '0;
  logic [CW-1:0] acc_ins = '0;

  function automatic logic [10:0] mk(input logic [2:0] st, input logic req, input logic we,
                                     input logic sel, input logic ir, input logic pc,
                                     input logic ru, input logic ill, input logic hlt);
    return {st, req, we, sel, ir, pc, ru, ill, hlt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic put(input logic [6:0] opc, input logic rdy, input logic [10:0] e);
    rec_t r;
    r.opc = opc;
    r.rdy = rdy;
    r.exp = e;
    sbq.push_back(r);
  endtask

  task automatic push_init();
    put(7'd0, 1'b1, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic push_fetch_wait(input logic [6:0] opc, input int n);
    for (int i = 0; i < n; i++) put(opc, 1'b0, mk(3'd1, 1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Full instruction trace: fw fetch waits, mw memory waits
  task automatic push_instr(input logic [6:0] opc, input int fw, input int mw);
    logic st, ldst, nord;
    st   = (opc == STORE);
    ldst = st || (opc == LOAD);
    nord = st || (opc == BRANCH);
    push_fetch_wait(opc, fw);
    put(opc, 1'b1, mk(3'd1, 1, 0, 0, 1, 0, 0, 0, 0));
    put(opc, 1'b1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0));
    put(opc, 1'b1, mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0));
    if (ldst) begin
      for (int i = 0; i < mw; i++) put(opc, 1'b0, mk(3'd4, 1, st, 1, 0, 0, 0, 0, 0));
      put(opc, 1'b1, mk(3'd4, 1, st, 1, 0, 0, 0, 0, 0));
    end
    put(opc, 1'b1, mk(3'd5, 0, 0, 0, 0, 1, !nord, 0, 0));
  endtask

  // Fetch + decode of a halting/trapping opcode, then n parked cycles
  task automatic push_stop(input logic [6:0] opc, input int n);
    logic trap;
    trap = (opc != SYSTEM);
    put(opc, 1'b1, mk(3'd1, 1, 0, 0, 1, 0, 0, 0, 0));
    put(opc, 1'b1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < n; i++)
      put(opc, 1'(i % 2), mk(trap ? 3'd7 : 3'd6, 0, 0, 0, 0, 0, 0, trap, 1));
  endtask

  task automatic drain();
    rec_t r;
    while (sbq.size() > 0) begin
      r = sbq.pop_front();
      OpCode    = r.opc;
      mem_ready = r.rdy;
      @(negedge clk);
      chk("outputs", 32'(obs), 32'(r.exp));
      chk("cycle_cnt", 32'(cycle_cnt), PERF ? 32'(acc_cyc) : 32'd0);
      chk("instr_cnt", 32'(instr_cnt), PERF ? 32'(acc_ins) : 32'd0);
      if (!(r.exp[10:8] inside {3'd0, 3'd6, 3'd7})) acc_cyc = acc_cyc + CW'(1);
      if (r.exp[10:8] == 3'd5) acc_ins = acc_ins + CW'(1);
      @(posedge clk);
      #1;
    end
  endtask

  // Reset pulse from a point just after a rising edge; released one edge later
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", 32'(obs), 32'(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0)));
    chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("rst_instr_cnt", 32'(instr_cnt), 32'd0);
    acc_cyc = '0;
    acc_ins = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // addi zero-wait: 1,2,3,5 then counters 4/1
    push_init();
    push_instr(ALUI, 0, 0);
    drain();
    chk("addi_cycle_cnt", 32'(cycle_cnt), PERF ? 32'd4 : 32'd0);
    chk("addi_instr_cnt", 32'(instr_cnt), PERF ? 32'd1 : 32'd0);
    chk("addi_back_to_fetch", 32'(state), 32'd1);

    // lw with two memory waits, sw with a fetch wait, beq, then the rest of the legal set
    push_instr(LOAD, 0, 2);
    push_instr(STORE, 1, 0);
    push_instr(BRANCH, 0, 0);
    push_instr(ALU, 2, 0);
    push_instr(JAL, 0, 0);
    push_instr(JALR, 0, 0);
    push_instr(LUI, 0, 0);
    push_instr(AUIPC, 0, 0);
    push_instr(STORE, 0, 3);
    drain();

    // ecall/ebreak class parks in HALT for 20 cycles with no request
    push_stop(SYSTEM, 20);
    drain();

    // Unsupported opcode traps, then reset clears the sticky flag
    do_reset();
    push_init();
    push_stop(7'b0000000, 3);
    drain();
    chk("trap_illegal", 32'(illegal), 32'd1);
    do_reset();
    chk("post_trap_illegal", 32'(illegal), 32'd0);
    push_init();
    push_instr(ALUI, 0, 0);
    drain();

    // Counter wrap: 16 active cycles on a 4-bit counter
    do_reset();
    push_init();
    for (int i = 0; i < 4; i++) push_instr(ALU, 0, 0);
    drain();
    chk("wrap_cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("wrap_instr_cnt", 32'(instr_cnt), PERF ? 32'd4 : 32'd0);

    // Reset asserted while FETCH is waiting on memory
    do_reset();
    push_init();
    push_fetch_wait(ALUI, 2);
    drain();
    mem_ready = 1'b0;
    chk("midfetch_req_before", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midfetch_async_drop", 32'(obs), 32'(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0)));
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("midfetch_held", 32'(obs), 32'(mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0)));
    chk("midfetch_cnt", 32'(cycle_cnt), 32'd0);
    acc_cyc = '0;
    acc_ins = '0;
    rst_n = 1'b1;
    push_init();
    push_instr(LOAD, 1, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
